// File: rtl/serial_magnitude_comparator_if.sv
// rtl/serial_magnitude_comparator_if.sv - request/verdict and nibble-comparator signals of the serial comparator
interface serial_magnitude_comparator_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         busy;
    logic         done;
    logic [2:0]   result;
    logic         err;
    logic [3:0]   cmp_a;
    logic [3:0]   cmp_b;
    logic [2:0]   cmp_r;

    modport master (
        output start, op_a, op_b, cmp_r,
        input  busy, done, result, err, cmp_a, cmp_b
    );

    modport slave (
        input  start, op_a, op_b, cmp_r,
        output busy, done, result, err, cmp_a, cmp_b
    );
endinterface

// File: rtl/serial_magnitude_comparator.sv
// rtl/serial_magnitude_comparator.sv - MSB-first nibble-serial magnitude comparator around an external 4-bit stage
module serial_magnitude_comparator #(
    parameter int NIBBLES = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    serial_magnitude_comparator_if.slave  bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [W-1:0]  reg_a;
    logic [W-1:0]  reg_b;
    logic [IW-1:0] idx;
    logic [IW+1:0] base;
    logic          busy_q;
    logic          done_q;
    logic [2:0]    result_q;
    logic          err_q;

    // Nibble select comes only from latched operands and the index register.
    assign base      = {idx, 2'b00};
    assign bus.cmp_a = (state == SCAN) ? reg_a[base +: 4] : 4'd0;
    assign bus.cmp_b = (state == SCAN) ? reg_b[base +: 4] : 4'd0;

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.err    = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            reg_a    <= '0;
            reg_b    <= '0;
            idx      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= 3'b000;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        reg_a  <= bus.op_a;
                        reg_b  <= bus.op_b;
                        idx    <= IW'(NIBBLES - 1);
                        err_q  <= 1'b0;
                        busy_q <= 1'b1;
                        state  <= SCAN;
                    end
                end
                SCAN: begin
                    case (bus.cmp_r)
                        3'b100, 3'b001: begin
                            result_q <= bus.cmp_r;
                            done_q   <= 1'b1;
                            state    <= DONE;
                        end
                        3'b010: begin
                            if (idx == '0) begin
                                result_q <= 3'b010;
                                done_q   <= 1'b1;
                                state    <= DONE;
                            end else begin
                                idx <= idx - 1'b1;
                            end
                        end
                        default: begin
                            // A corrupt stage code poisons the verdict rather than guessing.
                            result_q <= 3'b000;
                            err_q    <= 1'b1;
                            done_q   <= 1'b1;
                            state    <= DONE;
                        end
                    endcase
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule
